program_sequencer: RTL

- Sits directly upstream of the processor core and drives its Start input.
- Launches NUM_PROGS programs back to back: pulses Start, masks the stale done flag, waits for the core's Ack, measures run cycles, reports a per-program result, then advances.
- Provides watchdog timeout and abort so a hung program cannot stall the test harness.

---
 rtl/seq_pkg.sv | 15 +
 rtl/run_counter.sv | 23 ++
 rtl/program_sequencer.sv | 104 ++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// Shared types and defaults for the program sequencer.
package seq_pkg;

  typedef enum logic [2:0] {IDLE, START, MASK, RUN, REPORT, DONE} seq_state_t;

  localparam int          START_LEN_DEF = 2;
  localparam int          CYCLE_W_DEF   = 16;
  localparam int unsigned TIMEOUT_DEF   = 32'h0000_FFFF;

  // Index width for n items, never narrower than one bit.
  function automatic int prog_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/run_counter.sv
// Saturating run-cycle counter with clear/enable and a terminal compare.
module run_counter #(
  parameter int          CYCLE_W = 16,
  parameter int unsigned LIMIT   = 32'h0000_FFFF
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               clr,
  input  logic               en,
  output logic [CYCLE_W-1:0] cnt,
  output logic               at_limit
);

  assign at_limit = (cnt == CYCLE_W'(LIMIT));

  // Holding at the limit keeps the count from ever wrapping.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)                 cnt <= '0;
    else if (clr)               cnt <= '0;
    else if (en && !at_limit)   cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/program_sequencer.sv
// Launches NUM_PROGS programs on the core in turn and reports run cycles per program.
//   state  | meaning
//   IDLE   | waiting for Go
//   START  | Start held high for START_LEN cycles
//   MASK   | one cycle ignoring the previous program's stale Ack
//   RUN    | counting cycles until Ack or watchdog limit
//   REPORT | one-cycle result pulse
//   DONE   | one-cycle completion pulse
module program_sequencer
  import seq_pkg::*;
#(
  parameter int          NUM_PROGS = 3,
  parameter int          START_LEN = START_LEN_DEF,
  parameter int          CYCLE_W   = CYCLE_W_DEF,
  parameter int unsigned TIMEOUT   = TIMEOUT_DEF,
  localparam int         PW        = prog_w(NUM_PROGS)
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Go,
  input  logic               Abort,
  input  logic               Ack,
  output logic               Start,
  output logic [PW-1:0]      ProgSel,
  output logic               Busy,
  output logic               ResultValid,
  output logic [PW-1:0]      ResultIdx,
  output logic [CYCLE_W-1:0] CycleCt,
  output logic               Timeout,
  output logic               Done
);

  localparam int SW = prog_w(START_LEN);

  seq_state_t         state, nxt;
  logic [SW-1:0]      start_ct;
  logic [CYCLE_W-1:0] run_ct;
  logic               run_at_lim;
  logic               run_clr, run_en;

  assign run_clr = (state == IDLE) || (state == REPORT);
  assign run_en  = (state == MASK) || ((state == RUN) && !Ack);

  run_counter #(.CYCLE_W(CYCLE_W), .LIMIT(TIMEOUT)) u_run_ct (
    .Clk      (Clk),
    .Reset    (Reset),
    .clr      (run_clr),
    .en       (run_en),
    .cnt      (run_ct),
    .at_limit (run_at_lim)
  );

  // Abort also covers IDLE, where it simply suppresses Go.
  always_comb begin
    nxt = state;
    if (Abort) nxt = IDLE;
    else begin
      case (state)
        IDLE:    if (Go) nxt = START;
        START:   if (start_ct == SW'(START_LEN - 1)) nxt = MASK;
        MASK:    nxt = RUN;
        RUN:     if (Ack || run_at_lim) nxt = REPORT;
        REPORT:  nxt = (ProgSel == PW'(NUM_PROGS - 1)) ? DONE : START;
        DONE:    nxt = IDLE;
        default: nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state       <= IDLE;
      start_ct    <= '0;
      Start       <= 1'b0;
      ProgSel     <= '0;
      Busy        <= 1'b0;
      ResultValid <= 1'b0;
      ResultIdx   <= '0;
      CycleCt     <= '0;
      Timeout     <= 1'b0;
      Done        <= 1'b0;
    end else begin
      state       <= nxt;
      Start       <= (nxt == START);
      Busy        <= (nxt != IDLE);
      ResultValid <= (nxt == REPORT);
      Done        <= (nxt == DONE);

      if ((state == START) && (nxt == START)) start_ct <= start_ct + 1'b1;
      else                                    start_ct <= '0;

      if (nxt == IDLE)                             ProgSel <= '0;
      else if ((state == REPORT) && (nxt == START)) ProgSel <= ProgSel + 1'b1;

      // Only RUN reaches REPORT, so Ack low here means the watchdog fired.
      if (nxt == REPORT) begin
        CycleCt   <= run_ct;
        ResultIdx <= ProgSel;
        Timeout   <= !Ack;
      end
    end
  end

endmodule
